// File: rtl/riscv_fetch_queue_if.sv
// Fetch-side bus of the Riscv150 fetch queue: memory request/response,
// redirect from execute and the instruction stream toward decode.
interface riscv_fetch_queue_if;
  logic        stall;
  logic [31:0] imem_addr;
  logic        imem_re;
  logic        bios_re;
  logic [31:0] imem_rdata;
  logic [31:0] bios_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  stall, imem_rdata, bios_rdata, redirect_valid, redirect_pc, inst_ready,
    output imem_addr, imem_re, bios_re, misalign, inst_valid, inst, inst_pc
  );

  modport slave (
    output stall, imem_rdata, bios_rdata, redirect_valid, redirect_pc, inst_ready,
    input  imem_addr, imem_re, bios_re, misalign, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/riscv_fetch_queue.sv
// Instruction fetch front end: PC generator, one-cycle imem/BIOS request port
// and a DEPTH-entry instruction queue. Define FETCH_PERF_EN for perf counters.
module riscv_fetch_queue #(
  parameter int          DEPTH       = 4,
  parameter logic [31:0] RESET_PC    = 32'h4000_0000,
  parameter logic [3:0]  BIOS_NIBBLE = 4'h4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  riscv_fetch_queue_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]             perf_fetched,
  output logic [31:0]             perf_flushed
`endif
);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int STAGES = 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [31:0]       fetch_pc;
  logic [31:0]       req_pc;
  logic              req_bios;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW:0]       used;
  logic [STAGES:0]   vld_pipe;
  logic              issue;
  logic              pc_bios;
  logic              enq;
  logic              deq;

  // Credit: a slot is reserved at issue so the response can never overflow.
  assign used    = (CW+1)'(count) + (CW+1)'(inflight);
  assign pc_bios = (fetch_pc[31:28] == BIOS_NIBBLE);
  assign issue   = rst_n && !bus.stall && !bus.redirect_valid &&
                   (used < (CW+1)'(DEPTH));
  assign enq     = inflight && !bus.redirect_valid;
  assign deq     = (count != '0) && bus.inst_ready && !bus.stall && !bus.redirect_valid;

  always_comb begin
    vld_pipe = {inflight, issue};
  end

  assign bus.imem_addr  = fetch_pc;
  assign bus.imem_re    = vld_pipe[0] && !pc_bios;
  assign bus.bios_re    = vld_pipe[0] && pc_bios;
  assign bus.inst_valid = (count != '0);
  assign bus.inst       = mem[rd_ptr].inst;
  assign bus.inst_pc    = mem[rd_ptr].pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc     <= RESET_PC;
      req_pc       <= '0;
      req_bios     <= 1'b0;
      inflight     <= 1'b0;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      bus.misalign <= 1'b0;
    end else begin
      bus.misalign <= bus.redirect_valid && (|bus.redirect_pc[1:0]);
      inflight     <= vld_pipe[0];
      if (vld_pipe[0]) begin
        req_pc   <= fetch_pc;
        req_bios <= pc_bios;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (bus.redirect_valid) begin
        fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + AW'(1);
        if (deq) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= '{inst: (req_bios ? bus.bios_rdata : bus.imem_rdata), pc: req_pc};
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (vld_pipe[0]) perf_fetched <= perf_fetched + 32'd1;
      if (bus.redirect_valid)
        perf_flushed <= perf_flushed + 32'(count) + 32'(vld_pipe[1]);
    end
  end
`endif
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Randomised self-checking bench for riscv_fetch_queue against a queue-based
// transaction model of the fetch front end.
module tb_riscv_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h4000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  riscv_fetch_queue_if bus ();

  riscv_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .BIOS_NIBBLE(4'h4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_re  = 0;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_fly;
  logic [31:0] m_fly_pc;
  logic        m_mis;
  logic [31:0] req_addr;

  function automatic logic [31:0] ifun(logic [31:0] a);
    return a >> 2;
  endfunction

  function automatic logic [31:0] bfun(logic [31:0] a);
    return (a >> 2) ^ 32'hB105_0000;
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_pc  = RESET_PC;
    m_fly = 1'b0;
    m_mis = 1'b0;
  endfunction

  function automatic logic m_issue();
    return rst_n && !bus.stall && !bus.redirect_valid && (m_q.size() + int'(m_fly) < DEPTH);
  endfunction

  function automatic logic [99:0] exp_vec();
    logic iss, b, v;
    iss = m_issue();
    b   = (m_pc[31:28] == 4'h4);
    v   = (m_q.size() > 0);
    return {iss && !b, iss && b, m_pc, v, m_mis,
            v ? m_q[0].data : 32'h0, v ? m_q[0].pc : 32'h0};
  endfunction

  function automatic logic [99:0] obs_vec();
    logic v;
    v = (m_q.size() > 0);
    return {bus.imem_re, bus.bios_re, bus.imem_addr, bus.inst_valid, bus.misalign,
            v ? bus.inst : 32'h0, v ? bus.inst_pc : 32'h0};
  endfunction

  // Advance model and DUT across one rising edge; memories answer the
  // address presented this cycle with data valid the next cycle.
  task automatic tick();
    logic iss;
    iss = m_issue();
    req_addr = bus.imem_addr;
    if (bus.imem_re || bus.bios_re) n_re++;
    if (!rst_n) begin
      m_reset();
    end else if (bus.redirect_valid) begin
      m_q.delete();
      m_fly = 1'b0;
      m_pc  = {bus.redirect_pc[31:2], 2'b00};
      m_mis = |bus.redirect_pc[1:0];
    end else begin
      if (m_q.size() > 0 && bus.inst_ready && !bus.stall) void'(m_q.pop_front());
      if (m_fly)
        m_q.push_back('{pc: m_fly_pc, data: (m_fly_pc[31:28] == 4'h4) ? bfun(m_fly_pc) : ifun(m_fly_pc)});
      m_fly = iss;
      if (iss) begin
        m_fly_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
      m_mis = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.imem_rdata = ifun(req_addr);
    bus.bios_rdata = bfun(req_addr);
  endtask

  task automatic test_reset();
    logic [99:0] e, o;
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.inst_ready = 1'b1; bus.imem_rdata = '0; bus.bios_rdata = '0;
    m_reset();
    @(posedge clk); #1;
    #3;
    tests++;
    if ({bus.imem_re, bus.bios_re, bus.inst_valid, bus.misalign} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs got %b exp 0000", {bus.imem_re, bus.bios_re, bus.inst_valid, bus.misalign});
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #3;
      e = exp_vec(); o = obs_vec(); tests++;
      if (o !== e) begin fails++; $display("FAIL reset_release cyc%0d got %h exp %h", i, o, e); end
      if (i == 0) begin
        tests++;
        if (bus.imem_addr !== RESET_PC || bus.bios_re !== 1'b1 || bus.imem_re !== 1'b0) begin
          fails++;
          $display("FAIL first_fetch got addr %h bios %b exp addr %h bios 1", bus.imem_addr, bus.bios_re, RESET_PC);
        end
      end
      if (i == 2) begin
        tests++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== RESET_PC) begin
          fails++;
          $display("FAIL first_valid got v%b pc %h exp v1 pc %h", bus.inst_valid, bus.inst_pc, RESET_PC);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [99:0] e, o;
    int start;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_1000;
    #3;
    e = exp_vec(); o = obs_vec(); tests++;
    if (o !== e) begin fails++; $display("FAIL bp_redirect got %h exp %h", o, e); end
    tick();
    bus.redirect_valid = 1'b0;
    start = n_re;
    for (int i = 0; i < 20; i++) begin
      bus.inst_ready = (i >= 10);
      if (i == 10) begin
        tests++;
        if (n_re - start != DEPTH) begin
          fails++;
          $display("FAIL bp_issue_count got %0d exp %0d", n_re - start, DEPTH);
        end
      end
      #3;
      e = exp_vec(); o = obs_vec(); tests++;
      if (o !== e) begin fails++; $display("FAIL backpressure cyc%0d got %h exp %h", i, o, e); end
      tick();
    end
  endtask

  task automatic test_redirect();
    logic [99:0] e, o;
    logic [31:0] tgt [4];
    tgt[0] = 32'h0000_0100; tgt[1] = 32'h0000_0102; tgt[2] = 32'hFFFF_FFF8; tgt[3] = 32'h4000_0013;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 10; i++) begin
        bus.inst_ready     = (i < 4) ? 1'b0 : 1'b1;
        bus.redirect_valid = (i == 4);
        bus.redirect_pc    = tgt[t];
        #3;
        e = exp_vec(); o = obs_vec(); tests++;
        if (o !== e) begin fails++; $display("FAIL redirect t%0d cyc%0d got %h exp %h", t, i, o, e); end
        if (i == 5) begin
          tests++;
          if (bus.misalign !== (|tgt[t][1:0]) || bus.imem_addr !== {tgt[t][31:2], 2'b00} || bus.inst_valid !== 1'b0) begin
            fails++;
            $display("FAIL redirect_target t%0d got mis%b addr %h v%b exp mis%b addr %h v0",
                     t, bus.misalign, bus.imem_addr, bus.inst_valid, |tgt[t][1:0], {tgt[t][31:2], 2'b00});
          end
        end
        tick();
      end
    end
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [99:0] e, o;
    for (int i = 0; i < 14; i++) begin
      bus.inst_ready = 1'b1;
      bus.stall      = (i >= 3 && i < 6) || (i == 9) || (i == 10 && 1'b1);
      #3;
      e = exp_vec(); o = obs_vec(); tests++;
      if (o !== e) begin fails++; $display("FAIL stall cyc%0d got %h exp %h", i, o, e); end
      tick();
    end
    bus.stall = 1'b0;
  endtask

  task automatic test_random();
    logic [99:0] e, o;
    for (int i = 0; i < 600; i++) begin
      bus.stall          = ($urandom_range(0, 99) < 15);
      bus.inst_ready     = ($urandom_range(0, 99) < 65);
      bus.redirect_valid = ($urandom_range(0, 99) < 7);
      case ($urandom_range(0, 4))
        0: bus.redirect_pc = 32'h0000_0100;
        1: bus.redirect_pc = RESET_PC + {$urandom_range(0, 63), 2'b00};
        2: bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: bus.redirect_pc = $urandom;
      endcase
      #3;
      e = exp_vec(); o = obs_vec(); tests++;
      if (o !== e) begin fails++; $display("FAIL random cyc%0d got %h exp %h", i, o, e); end
      tick();
    end
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.inst_ready = 1'b1;
  endtask

  task automatic test_midreset();
    logic [99:0] e, o;
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    tests++;
    if (bus.inst_valid !== 1'b1 || m_q.size() != DEPTH) begin
      fails++;
      $display("FAIL midreset_full got v%b model %0d exp v1 model %0d", bus.inst_valid, m_q.size(), DEPTH);
    end
    rst_n = 1'b0;
    m_reset();
    #3;
    e = exp_vec(); o = obs_vec(); tests++;
    if (o !== e) begin fails++; $display("FAIL midreset_clear got %h exp %h", o, e); end
    tick();
    rst_n = 1'b1;
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #3;
      e = exp_vec(); o = obs_vec(); tests++;
      if (o !== e) begin fails++; $display("FAIL midreset_restart cyc%0d got %h exp %h", i, o, e); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_stall();
    test_random();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
